serial_sample_loader: RTL

Sequencer that fills the serial sample buffer before each fitness-evaluation run of the genetic serial-circuit evaluator. On a start pulse it walks sample indices 0..NUM_SAMPLES-1 and fetches each sample (input sequence, expected output, valid mask) from an upstream sample source. It then drives the buffer's prepare/write handshake to store the sample, and reports completion, progress or a timeout error to the run controller.

---
 rtl/serial_sample_loader_pkg.sv | 20 ++
 rtl/serial_sample_loader_timeout_counter.sv | 40 ++++
 rtl/serial_sample_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_sample_loader_pkg.sv
// Shared types for the serial sample loader: FSM state encoding, sample word
// shape and the width of the sample index.
package serial_loader_pkg;

    localparam int unsigned SAMPLE_INDEX_W = 32;

    typedef logic [3:0][7:0] sample_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_BUF,
        ST_PREPARE,
        ST_WRITE,
        ST_ADVANCE,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/serial_sample_loader_timeout_counter.sv
// Wait-state watchdog: counts cycles spent in a wait state and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1.
module loader_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic iClock,
    input  logic iReset_n,
    input  logic iClear,
    input  logic iEnable,
    output logic oTerminal
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        oTerminal = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Saturates at terminal so an unused enable can never wrap the count.
    always_comb begin
        count_d = count_q;
        if (iClear) begin
            count_d = '0;
        end else if (iEnable && !oTerminal) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_sample_loader.sv
// Walks sample indices 0..NUM_SAMPLES-1, fetches each sample from the source
// and pushes it into the serial sample buffer via the prepare/write handshake.
module serial_sample_loader
    import serial_loader_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      iClock,
    input  logic                      iReset_n,
    input  logic                      iStart,
    input  logic                      iAbort,
    output logic                      oSampleRequest,
    output logic [SAMPLE_INDEX_W-1:0] oSampleAddr,
    input  logic                      iSampleValid,
    input  logic [3:0][7:0]           iSampleInput,
    input  logic [3:0][7:0]           iSampleExpected,
    input  logic [3:0][7:0]           iSampleValidMask,
    input  logic                      iBufferReady,
    output logic                      oPreparingNextSample,
    output logic                      oWriteSample,
    output logic [SAMPLE_INDEX_W-1:0] oSampleIndex,
    output logic [3:0][7:0]           oCurrentSerialInput,
    output logic [3:0][7:0]           oCurrentSerialExpectedOutput,
    output logic [3:0][7:0]           oCurrentSerialValidOutput,
    output logic                      oBusy,
    output logic                      oDone,
    output logic                      oError
);

    localparam logic [SAMPLE_INDEX_W-1:0] LAST_INDEX = SAMPLE_INDEX_W'(NUM_SAMPLES - 1);

    loader_state_t               state_q, state_d;
    logic [SAMPLE_INDEX_W-1:0]   index_q, index_d;
    sample_word_t                input_q, input_d;
    sample_word_t                expected_q, expected_d;
    sample_word_t                mask_q, mask_d;
    logic                        abort_pend_q, abort_pend_d;
    logic                        tmo_clear;
    logic                        tmo_enable;
    logic                        tmo_terminal;

    loader_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .iClear   (tmo_clear),
        .iEnable  (tmo_enable),
        .oTerminal(tmo_terminal)
    );

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            input_q      <= '0;
            expected_q   <= '0;
            mask_q       <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            input_q      <= input_d;
            expected_q   <= expected_d;
            mask_q       <= mask_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Abort beats every other exit; a valid/ready arriving in the terminal
    // cycle still beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERROR: if (iStart && !iAbort) state_d = ST_FETCH;
            ST_FETCH: begin
                if (iAbort)            state_d = ST_IDLE;
                else if (iSampleValid) state_d = ST_WAIT_BUF;
                else if (tmo_terminal) state_d = ST_ERROR;
            end
            ST_WAIT_BUF: begin
                if (iAbort)            state_d = ST_IDLE;
                else if (iBufferReady) state_d = ST_PREPARE;
                else if (tmo_terminal) state_d = ST_ERROR;
            end
            ST_PREPARE: state_d = ST_WRITE;
            ST_WRITE:   state_d = (iAbort || abort_pend_q) ? ST_IDLE : ST_ADVANCE;
            ST_ADVANCE: begin
                if (iAbort)                      state_d = ST_IDLE;
                else if (index_q == LAST_INDEX)  state_d = ST_DONE;
                else                             state_d = ST_FETCH;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath updates are keyed off the chosen transition so they can never
    // disagree with the state register.
    always_comb begin
        index_d      = index_q;
        input_d      = input_q;
        expected_d   = expected_q;
        mask_d       = mask_q;
        abort_pend_d = 1'b0;
        if ((state_q == ST_IDLE || state_q == ST_ERROR) && state_d == ST_FETCH) begin
            index_d = '0;
        end
        if (state_q == ST_FETCH && state_d == ST_WAIT_BUF) begin
            input_d    = iSampleInput;
            expected_d = iSampleExpected;
            mask_d     = iSampleValidMask;
        end
        if (state_q == ST_PREPARE) begin
            abort_pend_d = iAbort;
        end
        if (state_q == ST_ADVANCE && state_d == ST_FETCH) begin
            index_d = index_q + SAMPLE_INDEX_W'(1);
        end
        tmo_enable = (state_q == ST_FETCH) || (state_q == ST_WAIT_BUF);
        tmo_clear  = (state_d != state_q) &&
                     ((state_d == ST_FETCH) || (state_d == ST_WAIT_BUF));
    end

    always_comb begin
        oSampleRequest               = (state_q == ST_FETCH);
        oPreparingNextSample         = (state_q == ST_PREPARE);
        oWriteSample                 = (state_q == ST_WRITE);
        oDone                        = (state_q == ST_DONE);
        oError                       = (state_q == ST_ERROR);
        oBusy                        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
        oSampleAddr                  = index_q;
        oSampleIndex                 = index_q;
        oCurrentSerialInput          = input_q;
        oCurrentSerialExpectedOutput = expected_q;
        oCurrentSerialValidOutput    = mask_q;
    end

endmodule
